// File: rtl/alex_spi_tx.sv
// -----------------------------------------------------------------------------
// alex_spi_tx
//
// Carries the decoded Alex filter/relay selections to the Alex board's shift
// registers. The parallel word {HPF, LPF, atten, TR} is watched for changes;
// whenever it differs from the last word sent (or a send is pending after
// reset), a 16-bit frame is shifted out MSB-first on a divided serial clock,
// followed by a load_strobe pulse so Alex latches every relay at once.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous, active-low reset
//   HPF[5:0]     in   one-hot HPF select (bit5 bypass .. bit0 13 MHz)
//   LPF[6:0]     in   one-hot LPF select
//   atten[1:0]   in   Alex attenuator select
//   TR           in   transmit/receive relay, 1 = TX
//   SPI_data     out  serial data, MSB first, valid around SPI_clock rise
//   SPI_clock    out  serial clock; Alex samples on the rising edge
//   load_strobe  out  active-high latch pulse after the 16th bit
//   busy         out  high from frame start until the end of the gap
//
// Parameters:
//   CLK_DIV         system clocks per serial half-period (1..255)
//   REFRESH_CYCLES  idle clocks before an unchanged word is resent
//
// Optional feature (macro ALEX_SPI_REFRESH_EN): periodic resend of the
// current word after REFRESH_CYCLES idle clocks, so Alex recovers its relay
// state after a power glitch on its side. Without the macro, frames are sent
// only after reset or on a word change.
// -----------------------------------------------------------------------------
module alex_spi_tx #(
    parameter int unsigned CLK_DIV        = 8,
    parameter logic [23:0] REFRESH_CYCLES = 24'd12_288_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] HPF,
    input  logic [6:0] LPF,
    input  logic [1:0] atten,
    input  logic       TR,
    output logic       SPI_data,
    output logic       SPI_clock,
    output logic       load_strobe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        STROBE,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic [15:0] last_sent_q, last_sent_d;
    logic        pending_q, pending_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic        spi_data_q, spi_data_d;
    logic        spi_clk_q, spi_clk_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;

    logic [15:0] word;
    logic        div_done;
    logic        refresh_due;
    logic        start_req;
    logic [3:0]  next_idx;

    assign word     = {HPF, LPF, atten, TR};
    assign div_done = (div_q == DIV_LAST);
    // Bit counter holds the index (0 = MSB) of the bit currently on the line;
    // the next bit to present is word bit 14 - bit_q.
    assign next_idx = 4'd14 - bit_q;

`ifdef ALEX_SPI_REFRESH_EN
    logic [23:0] idle_cnt_q, idle_cnt_d;

    // Expiry behaves like the pending flag but requests the resend directly,
    // so the refresh frame starts on the very edge the count expires.
    assign refresh_due = (state_q == IDLE) && (idle_cnt_q == REFRESH_CYCLES - 24'd1);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q == IDLE) begin
            idle_cnt_d = start_req ? 24'd0 : idle_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= 24'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic [23:0] unused_refresh_cycles;
    assign unused_refresh_cycles = REFRESH_CYCLES;
    assign refresh_due           = 1'b0;
`endif

    assign start_req = (word != last_sent_q) || pending_q || refresh_due;

    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;
        bit_d       = bit_q;
        div_d       = div_done ? 8'd0 : div_q + 8'd1;
        spi_data_d  = spi_data_q;
        spi_clk_d   = spi_clk_q;
        strobe_d    = strobe_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                if (start_req) begin
                    snapshot_d  = word;
                    last_sent_d = word;
                    pending_d   = 1'b0;
                    bit_d       = 4'd0;
                    spi_data_d  = word[15];
                    spi_clk_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_done) begin
                    spi_clk_d = 1'b1;
                    state_d   = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_done) begin
                    spi_clk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        spi_data_d = 1'b0;
                        strobe_d   = 1'b1;
                        state_d    = STROBE;
                    end else begin
                        // Data only moves on the falling serial clock edge.
                        bit_d      = bit_q + 4'd1;
                        spi_data_d = snapshot_q[next_idx];
                        state_d    = SHIFT_LO;
                    end
                end
            end
            STROBE: begin
                if (div_done) begin
                    strobe_d = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (div_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops every output at once; an interrupted frame never reaches
    // its strobe, so Alex keeps its previous relay state. pending forces a
    // full resend once reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            snapshot_q  <= 16'd0;
            last_sent_q <= 16'd0;
            pending_q   <= 1'b1;
            bit_q       <= 4'd0;
            div_q       <= 8'd0;
            spi_data_q  <= 1'b0;
            spi_clk_q   <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            spi_data_q  <= spi_data_d;
            spi_clk_q   <= spi_clk_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
        end
    end

    assign SPI_data    = spi_data_q;
    assign SPI_clock   = spi_clk_q;
    assign load_strobe = strobe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alex_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_alex_spi_tx
//
// Drives filter/relay words into alex_spi_tx and receives the serial frames
// the way Alex would: bits are captured on each SPI_clock rise and the frame
// is compared against a queue of expected words on each load_strobe rise.
// Frame timing (busy length, strobe length, idle gap) is measured on the
// falling system clock edge.
// -----------------------------------------------------------------------------
module tb_alex_spi_tx;

    localparam int CLK_DIV = 8;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] HPF;
    logic [6:0] LPF;
    logic [1:0] atten;
    logic       TR;
    logic       SPI_data;
    logic       SPI_clock;
    logic       load_strobe;
    logic       busy;

    always #5 clock = ~clock;

    alex_spi_tx #(
        .CLK_DIV        (CLK_DIV),
        .REFRESH_CYCLES (24'd1000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .HPF         (HPF),
        .LPF         (LPF),
        .atten       (atten),
        .TR          (TR),
        .SPI_data    (SPI_data),
        .SPI_clock   (SPI_clock),
        .load_strobe (load_strobe),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- receiver / monitors ----------------
    logic [15:0] rx_shift = 16'd0;
    int nbits           = 0;
    int spi_rises       = 0;
    int strobe_count    = 0;
    int frames_done     = 0;
    int busy_len        = 0;
    int last_busy_len   = 0;
    int strobe_len      = 0;
    int last_strobe_len = 0;
    int idle_len        = 0;
    int last_idle_len   = 0;
    int overlap_err     = 0;
    int data_err        = 0;

    initial forever begin
        @(posedge SPI_clock);
        rx_shift = {rx_shift[14:0], SPI_data};
        nbits++;
        spi_rises++;
    end

    initial forever begin
        logic [15:0] exp_word;
        @(posedge load_strobe);
        strobe_count++;
        check("frame_bits", nbits, 16);
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            $display("frame %0d received=%04h expected=%04h", strobe_count, rx_shift, exp_word);
            check("frame_word", rx_shift, exp_word);
        end
    end

    initial begin
        logic prev_busy   = 1'b0;
        logic prev_clk    = 1'b0;
        logic prev_data   = 1'b0;
        logic prev_strobe = 1'b0;
        logic prev_rst    = 1'b0;
        forever begin
            @(negedge clock);
            if (busy) begin
                if (!prev_busy) begin
                    last_idle_len = idle_len;
                    idle_len      = 0;
                    busy_len      = 0;
                    nbits         = 0;
                end
                busy_len++;
            end else begin
                if (prev_busy) begin
                    last_busy_len = busy_len;
                    frames_done++;
                end
                idle_len++;
            end
            if (load_strobe) begin
                if (!prev_strobe) strobe_len = 0;
                strobe_len++;
            end else if (prev_strobe) begin
                last_strobe_len = strobe_len;
            end
            if (load_strobe && SPI_clock) overlap_err++;
            if (reset_n && prev_rst && (SPI_data !== prev_data) &&
                !(prev_clk && !SPI_clock) && !(busy && !prev_busy)) data_err++;
            prev_busy   = busy;
            prev_clk    = SPI_clock;
            prev_data   = SPI_data;
            prev_strobe = load_strobe;
            prev_rst    = reset_n;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_frame(input string name, input int limit);
        int start;
        int n;
        start = frames_done;
        n     = 0;
        while (frames_done == start && n < limit) begin
            @(negedge clock);
            n++;
        end
        check({name, "_done"}, frames_done != start, 1);
    endtask

    task automatic check_frame_timing(input string name);
        check({name, "_busy_len"}, last_busy_len, 34 * CLK_DIV);
        check({name, "_strobe_len"}, last_strobe_len, CLK_DIV);
    endtask

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic [5:0]  hpf;
        logic [6:0]  lpf;
        logic [1:0]  at;
        logic        tr;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int r0;
        int f0;
        int s0;
        int n;

        vecs[0] = '{6'b001000, 7'b0000001, 2'b00, 1'b0, 16'h2008};
        vecs[1] = '{6'b100000, 7'b1000000, 2'b11, 1'b1, 16'h8207};
        vecs[2] = '{6'b000001, 7'b0100000, 2'b01, 1'b0, 16'h0502};
        vecs[3] = '{6'b000100, 7'b0000100, 2'b10, 1'b1, 16'h1025};
        vecs[4] = '{6'b000000, 7'b0000000, 2'b00, 1'b0, 16'h0000};
        vecs[5] = '{6'b111111, 7'b1111111, 2'b11, 1'b1, 16'hFFFF};

        // Reset state, then the pending frame after release.
        HPF = 6'b010000; LPF = 7'b0000001; atten = 2'b00; TR = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {SPI_data, SPI_clock, load_strobe, busy}, 4'b0000);
        exp_q.push_back(16'h4008);
        reset_n = 1'b1;
        @(negedge clock);
        check("release_busy", busy, 1);
        wait_frame("first", 1000);
        check_frame_timing("first");

        // Table of words: each change starts one frame one clock later.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #1;
            HPF = vecs[i].hpf; LPF = vecs[i].lpf; atten = vecs[i].at; TR = vecs[i].tr;
            exp_q.push_back(vecs[i].exp_word);
            @(negedge clock);
            check("latency_busy", busy, 1);
            check("first_bit", SPI_data, vecs[i].exp_word[15]);
            wait_frame("vec", 1000);
            check_frame_timing("vec");
        end

`ifndef ALEX_SPI_REFRESH_EN
        // Steady inputs: the line stays quiet.
        r0 = spi_rises;
        f0 = frames_done;
        repeat (10000) @(negedge clock);
        check("steady_spi_edges", spi_rises, r0);
        check("steady_frames", frames_done, f0);
`else
        // Static word resent after each 1000-clock idle stretch.
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFFF);
        wait_frame("refresh1", 3000);
        check("refresh1_idle", last_idle_len, 1000);
        wait_frame("refresh2", 3000);
        check("refresh2_idle", last_idle_len, 1000);
        check_frame_timing("refresh");
`endif

        // Change during a frame: in-flight frame unchanged, next frame
        // starts one clock after busy falls.
        @(negedge clock);
        #1;
        HPF = 6'b010000; LPF = 7'b0000001; atten = 2'b00; TR = 1'b0;
        exp_q.push_back(16'h4008);
        repeat (100) @(negedge clock);
        HPF = 6'b001000;
        exp_q.push_back(16'h2008);
        wait_frame("mid_a", 1000);
        wait_frame("mid_b", 1000);
        check("mid_gap", last_idle_len, 1);
        check_frame_timing("mid_b");

        // Several changes in one frame, including a TR toggle, collapse into
        // one follow-up frame with the latest value.
        @(negedge clock);
        #1;
        HPF = 6'b000010;
        exp_q.push_back(16'h0808);
        repeat (40) @(negedge clock);
        TR = 1'b1;
        repeat (40) @(negedge clock);
        HPF = 6'b000001;
        repeat (40) @(negedge clock);
        TR = 1'b0;
        exp_q.push_back(16'h0408);
        wait_frame("col_a", 1000);
        wait_frame("col_b", 1000);
        check("col_gap", last_idle_len, 1);
        check("col_tr_bit", rx_shift[0], 0);
        f0 = frames_done;
        repeat (500) @(negedge clock);
        check("col_no_extra", frames_done, f0);

        // Reset in the middle of bit 7: outputs drop at once, no strobe,
        // full resend afterwards.
        @(negedge clock);
        #1;
        HPF = 6'b111111; LPF = 7'b1111111; atten = 2'b11; TR = 1'b1;
        r0 = spi_rises;
        n  = 0;
        while (spi_rises - r0 < 8 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("bit7_reached", spi_rises - r0, 8);
        repeat (2) @(negedge clock);
        check("pre_reset_lines", {SPI_data, SPI_clock, busy}, 3'b111);
        s0 = strobe_count;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {SPI_data, SPI_clock, load_strobe, busy}, 4'b0000);
        repeat (5) @(negedge clock);
        check("no_partial_strobe", strobe_count, s0);
        exp_q.push_back(16'hFFFF);
        reset_n = 1'b1;
        wait_frame("after_reset", 1000);
        check_frame_timing("after_reset");

        check("strobe_overlap", overlap_err, 0);
        check("data_change_rule", data_err, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
